// File: rtl/trivium_prng.sv
// rtl/trivium_prng.sv - Trivium keystream PRNG, UNROLL rounds per clock, 128-bit words on request
// Optional macro TRIVIUM_PRNG_PREFETCH_EN: keep one keystream word generated ahead of requests.
module trivium_prng #(
  parameter int UNROLL      = 64,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] seed,
  input  logic         reseed,
  output logic         reseed_ack,
  output logic [127:0] rdi_data,
  output logic         rdi_valid,
  input  logic         rdi_ready
);
  localparam int INIT_CYCLES = INIT_ROUNDS / UNROLL;
  localparam int GEN_CYCLES  = 128 / UNROLL;
  localparam int MAX_CYCLES  = (INIT_CYCLES > GEN_CYCLES) ? INIT_CYCLES : GEN_CYCLES;
  localparam int CNT_W       = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(GEN_CYCLES - 1);

  typedef enum logic [1:0] {UNSEEDED, INIT, READY, GEN} state_t;

  state_t             state;
  logic [287:0]       st;
  logic [287:0]       st_nxt;
  logic [UNROLL-1:0]  ks;
  logic [127:0]       word;
  logic [127:0]       word_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               pending;
  logic               req;
  logic               unused_seed;
`ifdef TRIVIUM_PRNG_PREFETCH_EN
  logic [127:0]       pf_buf;
  logic               pf_full;
`endif

  // Returns {z, next_state}; bit k of the state vector holds Trivium s[k+1].
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  function automatic logic [287:0] load_state(input logic [255:0] sd);
    logic [287:0] s;
    s          = '0;
    s[79:0]    = sd[79:0];
    s[172:93]  = sd[159:80];
    s[287:285] = 3'b111;
    return s;
  endfunction

  always_comb begin
    logic [287:0] s;
    logic [288:0] r;
    s  = st;
    r  = '0;
    ks = '0;
    for (int u = 0; u < UNROLL; u++) begin
      r     = trivium_round(s);
      ks[u] = r[288];
      s     = r[287:0];
    end
    st_nxt = s;
  end

  // Earliest keystream bits end up at the bottom of the word after GEN_CYCLES shifts.
  assign word_nxt    = {ks, word[127:UNROLL]};
  assign req         = pending | rdi_ready;
  assign unused_seed = ^seed[255:160];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UNSEEDED;
      st         <= '0;
      word       <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      reseed_ack <= 1'b0;
      rdi_valid  <= 1'b0;
      rdi_data   <= '0;
`ifdef TRIVIUM_PRNG_PREFETCH_EN
      pf_buf     <= '0;
      pf_full    <= 1'b0;
`endif
    end else begin
      reseed_ack <= 1'b0;
      rdi_valid  <= 1'b0;
      // A delivery below clears pending after this, so a request landing on it is dropped.
      if (rdi_ready) pending <= 1'b1;
      if (reseed) begin
        st    <= load_state(seed);
        cnt   <= '0;
        state <= INIT;
`ifdef TRIVIUM_PRNG_PREFETCH_EN
        pf_full <= 1'b0;
`endif
      end else begin
        case (state)
          UNSEEDED: ;
          INIT: begin
            st  <= st_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == INIT_LAST) begin
              reseed_ack <= 1'b1;
              cnt        <= '0;
`ifdef TRIVIUM_PRNG_PREFETCH_EN
              state      <= GEN;
`else
              state      <= READY;
`endif
            end
          end
          READY: begin
`ifdef TRIVIUM_PRNG_PREFETCH_EN
            if (pf_full && req) begin
              rdi_data  <= pf_buf;
              rdi_valid <= 1'b1;
              pending   <= 1'b0;
              pf_full   <= 1'b0;
              cnt       <= '0;
              state     <= GEN;
            end
`else
            if (req) begin
              cnt   <= '0;
              state <= GEN;
            end
`endif
          end
          GEN: begin
            st   <= st_nxt;
            word <= word_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == GEN_LAST) begin
              cnt <= '0;
`ifdef TRIVIUM_PRNG_PREFETCH_EN
              if (req) begin
                rdi_data  <= word_nxt;
                rdi_valid <= 1'b1;
                pending   <= 1'b0;
                state     <= GEN;
              end else begin
                pf_buf  <= word_nxt;
                pf_full <= 1'b1;
                state   <= READY;
              end
`else
              rdi_data  <= word_nxt;
              rdi_valid <= 1'b1;
              pending   <= 1'b0;
              state     <= READY;
`endif
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_trivium_prng.sv
// tb/tb_trivium_prng.sv - directed bench for trivium_prng (UNROLL 64 and 8) against a bit-serial model
module tb_trivium_prng;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] seed;
  logic         reseed, rdi_ready, reseed_ack, rdi_valid;
  logic [127:0] rdi_data;
  logic         reseed8, rdi_ready8, reseed_ack8, rdi_valid8;
  logic [127:0] rdi_data8;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt = 0, valid_cnt = 0, overlap_cnt = 0;

  logic         m_s [1:288];
  logic [127:0] w_zero [4];
  logic [127:0] w_s1;
  logic [255:0] s1 = 256'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB;

  trivium_prng dut (
    .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .reseed_ack(reseed_ack),
    .rdi_data(rdi_data), .rdi_valid(rdi_valid), .rdi_ready(rdi_ready)
  );

  trivium_prng #(.UNROLL(8)) dut8 (
    .clk(clk), .rst(rst), .seed(seed), .reseed(reseed8), .reseed_ack(reseed_ack8),
    .rdi_data(rdi_data8), .rdi_valid(rdi_valid8), .rdi_ready(rdi_ready8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reseed_ack) ack_cnt++;
    if (rdi_valid) valid_cnt++;
    if ((rdi_valid && reseed_ack) || (rdi_valid8 && reseed_ack8)) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_round(output logic z);
    logic t1, t2, t3;
    t1 = m_s[66] ^ m_s[93];
    t2 = m_s[162] ^ m_s[177];
    t3 = m_s[243] ^ m_s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m_s[91] & m_s[92]) ^ m_s[171];
    t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
    t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
    for (int i = 93; i > 1; i--) m_s[i] = m_s[i-1];
    m_s[1] = t3;
    for (int i = 177; i > 94; i--) m_s[i] = m_s[i-1];
    m_s[94] = t1;
    for (int i = 288; i > 178; i--) m_s[i] = m_s[i-1];
    m_s[178] = t2;
  endtask

  task automatic model_seed(input logic [255:0] sd);
    logic z;
    for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
    for (int i = 0; i < 80; i++) m_s[i+1] = sd[i];
    for (int i = 0; i < 80; i++) m_s[i+94] = sd[i+80];
    m_s[286] = 1'b1; m_s[287] = 1'b1; m_s[288] = 1'b1;
    for (int r = 0; r < 1152; r++) model_round(z);
  endtask

  task automatic model_word(output logic [127:0] w);
    logic z;
    w = '0;
    for (int i = 0; i < 128; i++) begin
      model_round(z);
      w[i] = z;
    end
  endtask

  // Returns edges counted from the one sampling the pulse (edge 1) until the response is high.
  task automatic do_reseed(input bit use8, output int n);
    if (use8) reseed8 = 1'b1; else reseed = 1'b1;
    tick;
    reseed = 1'b0; reseed8 = 1'b0;
    n = 1;
    while (!(use8 ? reseed_ack8 : reseed_ack) && n < 400) begin tick; n++; end
  endtask

  task automatic do_request(input bit use8, output int n);
    if (use8) rdi_ready8 = 1'b1; else rdi_ready = 1'b1;
    tick;
    rdi_ready = 1'b0; rdi_ready8 = 1'b0;
    n = 1;
    while (!(use8 ? rdi_valid8 : rdi_valid) && n < 100) begin tick; n++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rdi_valid && n < 100) begin tick; n++; end
  endtask

  initial begin
    int n;
    int vc;
    rst = 1'b1; seed = '0; reseed = 1'b0; rdi_ready = 1'b0; reseed8 = 1'b0; rdi_ready8 = 1'b0;

    model_seed(256'h0);
    for (int k = 0; k < 4; k++) model_word(w_zero[k]);
    model_seed(s1);
    model_word(w_s1);

    tick; tick; tick;
    check("reset_ack", 128'(reseed_ack), 128'(0));
    check("reset_valid", 128'(rdi_valid), 128'(0));
    check("reset_data", rdi_data, 128'h0);
    #4 rst = 1'b0;
    tick;

    // Two requests before any seed: the first is held pending, the second is dropped.
    rdi_ready = 1'b1; tick; rdi_ready = 1'b0;
    repeat (5) tick;
    check("unseeded_no_valid", 128'(valid_cnt), 128'(0));
    rdi_ready = 1'b1; tick; rdi_ready = 1'b0;
    seed = 256'h0;
    do_reseed(1'b0, n);
    check("ack_latency_seed0", 128'(n), 128'(19));
    wait_valid(n);
    check("pending_after_ack_latency", 128'(n), 128'(3));
    check("seed0_word0", rdi_data, w_zero[0]);
    repeat (10) tick;
    check("early_dup_dropped", 128'(valid_cnt), 128'(1));
    check("ack_one_pulse", 128'(ack_cnt), 128'(1));
    for (int k = 1; k < 4; k++) begin
      do_request(1'b0, n);
      check($sformatf("req_latency_%0d", k), 128'(n), 128'(3));
      check($sformatf("seed0_word%0d", k), rdi_data, w_zero[k]);
      repeat (10) tick;
    end
    check("data_stable", rdi_data, w_zero[3]);

    // Asynchronous reset while a word is being generated.
    rdi_ready = 1'b1; tick; rdi_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", 128'(reseed_ack), 128'(0));
    check("async_rst_valid", 128'(rdi_valid), 128'(0));
    check("async_rst_data", rdi_data, 128'h0);
    #3 rst = 1'b0;
    tick;
    vc = valid_cnt;
    rdi_ready = 1'b1; tick; rdi_ready = 1'b0;
    repeat (10) tick;
    check("post_rst_no_valid", 128'(valid_cnt), 128'(vc));

    // Pending request starts GEN after the ack; reseed lands on its final step.
    seed = s1;
    do_reseed(1'b0, n);
    check("ack_latency_s1", 128'(n), 128'(19));
    tick; tick;
    seed = s1 | {96'hA5A5_5A5A_DEAD_BEEF_1234_5678, 160'h0};
    do_reseed(1'b0, n);
    check("ack_latency_reseed_gen", 128'(n), 128'(19));
    check("aborted_word_no_valid", 128'(valid_cnt), 128'(vc));
    wait_valid(n);
    check("pending_kept_latency", 128'(n), 128'(3));
    check("s1_word0_upper_ignored", rdi_data, w_s1);

    // UNROLL = 8 instance, all-zero seed.
    seed = 256'h0;
    do_reseed(1'b1, n);
    check("u8_ack_latency", 128'(n), 128'(145));
    do_request(1'b1, n);
    check("u8_req_latency", 128'(n), 128'(17));
    check("u8_word0", rdi_data8, w_zero[0]);
    tick;
    do_request(1'b1, n);
    check("u8_word1", rdi_data8, w_zero[1]);

    check("ack_valid_overlap", 128'(overlap_cnt), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trivium_prng.md
Name: trivium_prng

Overview:
- Keystream source that answers the polynomial samplers' PRNG interface: `seed`/`reseed`/`reseed_ack` and `rdi_data`/`rdi_valid`/`rdi_ready`.
- Runs a Trivium cipher unrolled UNROLL rounds per clock and delivers 128-bit keystream words on request.
- Sits between the seed-loading consumers (e.g. the uniform sampler for polynomial a) and nothing else; one instance is shared per consumer.

Parameters:
- UNROLL, 64, Trivium rounds per clock; legal values 1, 2, 4, 8, 16, 32, 64; must divide 128 and INIT_ROUNDS.
- INIT_ROUNDS, 1152, warm-up rounds discarded after a (re)seed.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seed  input  256  seed value; key = seed[79:0], IV = seed[159:80], seed[255:160] ignored.
- reseed  input  1  one-cycle pulse; samples seed and restarts the cipher.
- reseed_ack  output  1  one-cycle pulse when warm-up completes.
- rdi_data  output  128  keystream word; stable between rdi_valid pulses.
- rdi_valid  output  1  one-cycle pulse: a new word is on rdi_data.
- rdi_ready  input  1  one-cycle request pulse for the next word.

Behaviour:
- Reset (async, active-high): all outputs 0, cipher state 0, pending = 0, state UNSEEDED.
- Load on reseed:
  - s[1..80] = seed[0..79]; s[81..93] = 0.
  - s[94..173] = seed[80..159]; s[174..177] = 0.
  - s[178..285] = 0; s[286..288] = 1.
- Round function: standard Trivium. Keystream bit i of a word goes to rdi_data[i], first-generated bit in bit 0.
- pending flag:
  - Set by rdi_ready in any state, including UNSEEDED and INIT.
  - Cleared when a word is delivered.
  - A request while pending = 1 is dropped; there is no queue.
- States:
  - UNSEEDED: no generation; requests only set pending. reseed -> INIT.
  - INIT: UNROLL rounds per cycle, output discarded, for INIT_ROUNDS/UNROLL cycles (18 at default). At completion, reseed_ack = 1 for one cycle -> READY.
  - READY: if pending, or rdi_ready this cycle -> GEN.
  - GEN: 128/UNROLL cycles (2 at default), shifting keystream into a word register. On the final step: rdi_data <= word, rdi_valid = 1 for one cycle, pending <= 0 -> READY.
- Latency at default UNROLL:
  - Edge sampling reseed to reseed_ack high: 19 edges.
  - Request sampled in READY to rdi_valid high: 3 edges.
  - A request pending through INIT yields rdi_valid 3 edges after reseed_ack.
- reseed in INIT/GEN/READY: reload and restart INIT. Any partial word is discarded with no rdi_valid for it. pending is preserved. rdi_data keeps its last value.
- reseed and rdi_ready in the same cycle: both take effect.
- reseed_ack and rdi_valid are never high simultaneously.
- Cipher never advances in READY; consecutive words are contiguous keystream.

Optional Feature:
- Macro: TRIVIUM_PRNG_PREFETCH_EN.
- Defined:
  - After reseed_ack and after each delivery, GEN runs immediately into a 128-bit prefetch buffer with a full flag.
  - A request with the buffer full delivers with rdi_valid 1 edge after the sampling edge, then refills.
  - Request with the buffer filling: delivered on fill completion.
  - reseed clears the full flag.
  - Keystream order is identical to the non-prefetch build.
- Undefined: on-demand generation as above; no prefetch buffer.

Test Plan:
- Reset mid-GEN:
  - Stimulus: assert rst asynchronously between clock edges.
  - Response: reseed_ack, rdi_valid, rdi_data drop to 0 immediately.
  - Response: a request after release gives no rdi_valid until a reseed.
- Seed = 0, reseed, then 4 requests spaced 10 cycles:
  - Response: reseed_ack exactly 19 edges after reseed.
  - Response: each rdi_valid 3 edges after its request (1 with PREFETCH_EN after the buffer is full).
  - Response: words match the golden C Trivium model (key = 0, IV = 0, 1152 warm-up, LSB-first) for keystream bits 0-511.
- rdi_ready pulsed before reseed, then reseed:
  - Response: exactly one rdi_valid, 3 edges after reseed_ack.
  - Response: a second early request is dropped; only one word is delivered.
- Seed = 256'h…0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB, reseed issued 1 cycle into GEN:
  - Response: no rdi_valid for the aborted word.
  - Response: the subsequent word equals golden-model bits 0-127 for the new key/IV.
  - Response: seed[255:160] variations do not change output.
- UNROLL = 8 build, same seed as the second scenario:
  - Response: identical words.
  - Response: reseed_ack 145 edges after reseed; rdi_valid 17 edges after request.
